// File: rtl/cnt_universal.sv
// Modulo-N up/down counter with clear, clamped parallel load, wrap or saturate at the limits,
// one-cycle overflow/underflow pulses and a Gray-coded copy of the count.
module cnt_universal #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MODULUS  = 16,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_gray,
  output logic             tc,
  output logic             ovf,
  output logic             unf
);

  localparam longint unsigned Span = 64'd1 << WIDTH;
  localparam logic [WIDTH-1:0] Max = WIDTH'(MODULUS - 1);

  generate
    if (WIDTH < 1 || MODULUS < 2 || 64'(MODULUS) > Span) begin : g_bad_params
      $error("cnt_universal: illegal WIDTH/MODULUS combination");
    end
  endgenerate

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             at_max, at_zero, above_max;

  assign at_max    = (cnt_q == Max);
  assign at_zero   = (cnt_q == '0);
  assign above_max = (cnt_q > Max);

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = (d > Max) ? Max : d;
    end else if (en) begin
      if (up) begin
        // Out-of-range values can only come from a fault; recover without flagging.
        if (above_max) begin
          cnt_d = '0;
        end else if (at_max) begin
          cnt_d = SATURATE ? Max : '0;
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        if (above_max) begin
          cnt_d = Max;
        end else if (at_zero) begin
          cnt_d = SATURATE ? '0 : Max;
          unf_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign q      = cnt_q;
  assign q_gray = cnt_q ^ (cnt_q >> 1);
  assign tc     = en & ((up & at_max) | (~up & at_zero));
  assign ovf    = ovf_q;
  assign unf    = unf_q;

endmodule
